// File: rtl/mont_xfer_pkg.sv
// Shared types and helpers for the Montgomery-domain converter.
// Optional input checking is enabled by defining MONT_XFER_CHECK_EN.
package mont_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_TO_MONT = 1'b1;
  localparam logic MODE_TO_REG  = 1'b0;

  // Never narrower than one bit, so SHIFTS=1 still gets a counter.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mont_xfer_lane.sv
// One residue channel: pre-reduce on load, then a modular
// double (into Montgomery form) or halve (out of it) per step.
module mont_xfer_lane
  import mont_xfer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_prime,
  input  logic [WIDTH-1:0] i_x,
  output logic [WIDTH-1:0] o_x
);

  logic [WIDTH-1:0] r_x;
  logic [WIDTH:0]   w_pz;
  logic [WIDTH:0]   w_xz;
  logic [WIDTH:0]   w_d;
  logic [WIDTH:0]   w_s;
  logic [WIDTH-1:0] w_pre;
  logic [WIDTH-1:0] w_dbl;
  logic [WIDTH-1:0] w_hlv;

  assign w_pz = {1'b0, i_prime};
  assign w_xz = {1'b0, i_x};
  assign w_d  = {r_x, 1'b0};
  // Adding P to an odd value keeps the halving exact.
  assign w_s  = {1'b0, r_x} + (r_x[0] ? w_pz : '0);

  always_comb begin
    w_pre = WIDTH'((w_xz >= w_pz) ? w_xz - w_pz : w_xz);
    w_dbl = WIDTH'((w_d >= w_pz) ? w_d - w_pz : w_d);
    w_hlv = WIDTH'(w_s >> 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x <= '0;
    end else if (i_load) begin
      r_x <= w_pre;
    end else if (i_step) begin
      r_x <= (i_mode == MODE_TO_MONT) ? w_dbl : w_hlv;
    end
  end

  assign o_x = r_x;

endmodule

// File: rtl/mont_domain_xfer.sv
// NCH-channel bit-serial Montgomery-domain converter, R = 2^SHIFTS.
// Define MONT_XFER_CHECK_EN to build the input-check err flag.
module mont_domain_xfer
  import mont_xfer_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NCH    = 3,
  parameter int SHIFTS = WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 to_mont,
  input  logic [WIDTH-1:0]     prime,
  input  logic [NCH*WIDTH-1:0] x_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] x_out,
  output logic                 err
);

  localparam int CW = clog2(SHIFTS);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_mode;
  logic [WIDTH-1:0] r_prime;

  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic [WIDTH-1:0] w_prime;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_step   = (r_state == RUN);
  assign w_last   = (r_cnt == CW'(SHIFTS - 1));
  // Pre-reduction on load needs the prime before it is latched.
  assign w_prime  = (r_state == IDLE) ? prime : r_prime;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_mode      <= MODE_TO_MONT;
      r_prime     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state    <= RUN;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_mode     <= to_mont;
            r_prime    <= prime;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    mont_xfer_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_accept),
      .i_step (w_step),
      .i_mode (r_mode),
      .i_prime(w_prime),
      .i_x    (x_in[k*WIDTH +: WIDTH]),
      .o_x    (x_out[k*WIDTH +: WIDTH])
    );
  end

`ifdef MONT_XFER_CHECK_EN
  logic r_err;
  logic w_bad;

  always_comb begin
    w_bad = ~prime[0] | (prime < WIDTH'(3));
    for (int k = 0; k < NCH; k++) begin
      if ({1'b0, x_in[k*WIDTH +: WIDTH]} >= {prime, 1'b0}) begin
        w_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_bad;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mont_domain_xfer.sv
// Randomised self-checking bench for mont_domain_xfer.
// Build with MONT_XFER_CHECK_EN to exercise the err flag.
module tb_mont_domain_xfer;

  localparam int W = 9;
  localparam int S = 8;
  localparam int N = 3;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic           to_mont;
  logic [W-1:0]   prime;
  logic [N*W-1:0] x_in;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] x_out;
  logic           err;

  int errors = 0;
  int checks = 0;

  mont_domain_xfer #(
    .WIDTH (W),
    .NCH   (N),
    .SHIFTS(S)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .to_mont  (to_mont),
    .prime    (prime),
    .x_in     (x_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_out    (x_out),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] pack3(input int a, input int b,
                                           input int c);
    return {W'(c), W'(b), W'(a)};
  endfunction

  function automatic int ch(input logic [N*W-1:0] v, input int k);
    return int'(v[k*W +: W]);
  endfunction

  // x * 2^S mod p, or x * (2^-1)^S mod p, by plain modular arithmetic.
  function automatic int conv(input bit m, input int p, input int x);
    longint r;
    longint f;
    r = longint'(x) % p;
    f = m ? 2 : (p + 1) / 2;
    for (int i = 0; i < S; i++) r = (r * f) % p;
    return int'(r);
  endfunction

  task automatic xfer(input logic m, input int p, input logic [N*W-1:0] x,
                      output logic [N*W-1:0] y, output logic e,
                      output int lat);
    int n;
    @(negedge clk);
    to_mont  = m;
    prime    = W'(p);
    x_in     = x;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("FAIL xfer_ready: in_ready got 0 want 1 after 20 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      errors++;
      checks++;
      $display("FAIL xfer_timeout: out_valid got 0 want 1 after 40 cycles");
    end
    y = x_out;
    e = err;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || err !== 1'b0 ||
        x_out !== '0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b err=%b x=%h want 1 0 0 0",
               in_ready, out_valid, err, x_out);
    end
  endtask

  task automatic test_basic;
    logic [N*W-1:0] y;
    logic           e;
    int             lat;
    int             ea[3];
    int             eb[3];
    ea = '{5, 10, 246};
    eb = '{1, 2, 250};
    xfer(1'b1, 251, pack3(1, 2, 250), y, e, lat);
    checks++;
    if (lat !== S + 1) begin
      errors++;
      $display("FAIL latency: got %0d want %0d", lat, S + 1);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (ch(y, k) !== ea[k]) begin
        errors++;
        $display("FAIL to_mont ch%0d: got %0d want %0d", k, ch(y, k), ea[k]);
      end
    end
    checks++;
    if (e !== 1'b0) begin
      errors++;
      $display("FAIL err_legal: got %b want 0", e);
    end
    xfer(1'b0, 251, pack3(5, 10, 246), y, e, lat);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (ch(y, k) !== eb[k]) begin
        errors++;
        $display("FAIL to_reg ch%0d: got %0d want %0d", k, ch(y, k), eb[k]);
      end
    end
  endtask

  task automatic test_prereduce;
    logic [N*W-1:0] y;
    logic           e;
    int             lat;
    int             ea[3];
    ea = '{0, 0, 246};
    xfer(1'b1, 251, pack3(251, 0, 501), y, e, lat);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (ch(y, k) !== ea[k]) begin
        errors++;
        $display("FAIL prereduce ch%0d: got %0d want %0d", k, ch(y, k),
                 ea[k]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [N*W-1:0] y;
    int             n;
    @(negedge clk);
    to_mont  = 1'b1;
    prime    = W'(251);
    x_in     = pack3(7, 100, 200);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    y = x_out;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (ch(y, k) !== conv(1'b1, 251, ch(x_in, k))) begin
        errors++;
        $display("FAIL bp_value ch%0d: got %0d want %0d", k, ch(y, k),
                 conv(1'b1, 251, ch(x_in, k)));
      end
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || x_out !== y || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: vld=%b x=%h rdy=%b want 1 %h 0",
                 out_valid, x_out, in_ready, y);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b want 0 1", out_valid,
               in_ready);
    end
  endtask

  task automatic test_midrun_reset;
    logic [N*W-1:0] y;
    logic           e;
    int             lat;
    int             seen;
    @(negedge clk);
    to_mont  = 1'b1;
    prime    = W'(251);
    x_in     = pack3(9, 9, 9);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: rdy=%b vld=%b want 1 0", in_ready,
               out_valid);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midrun_novalid: got %0d valid cycles want 0", seen);
    end
    xfer(1'b1, 251, pack3(1, 1, 1), y, e, lat);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (ch(y, k) !== 5) begin
        errors++;
        $display("FAIL after_reset ch%0d: got %0d want 5", k, ch(y, k));
      end
    end
  endtask

  task automatic test_back_to_back;
    int q[$];
    int n;
    @(negedge clk);
    to_mont   = 1'b1;
    prime     = W'(251);
    x_in      = pack3(3, 4, 5);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (in_ready) q.push_back(c);
      if (out_valid) begin
        for (int k = 0; k < N; k++) begin
          checks++;
          if (ch(x_out, k) !== conv(1'b1, 251, ch(x_in, k))) begin
            errors++;
            $display("FAIL b2b_value ch%0d: got %0d want %0d", k,
                     ch(x_out, k), conv(1'b1, 251, ch(x_in, k)));
          end
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (q.size() < 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d accepts want >= 3", q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (q[i] - q[i-1] !== S + 2) begin
          errors++;
          $display("FAIL b2b_period: got %0d want %0d", q[i] - q[i-1],
                   S + 2);
        end
      end
    end
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_err;
    logic [N*W-1:0] y;
    logic           e;
    logic           want;
    int             lat;
`ifdef MONT_XFER_CHECK_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    xfer(1'b1, 250, pack3(1, 2, 3), y, e, lat);
    checks++;
    if (e !== want) begin
      errors++;
      $display("FAIL err_even_p: got %b want %b", e, want);
    end
    xfer(1'b1, 251, pack3(502, 0, 0), y, e, lat);
    checks++;
    if (e !== want) begin
      errors++;
      $display("FAIL err_big_x: got %b want %b", e, want);
    end
    xfer(1'b1, 251, pack3(10, 20, 30), y, e, lat);
    checks++;
    if (e !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b want 0", e);
    end
  endtask

  task automatic test_roundtrip;
    int             pl[4];
    int             p;
    int             lim;
    int             xv[3];
    logic [N*W-1:0] y;
    logic [N*W-1:0] z;
    logic           e;
    int             lat;
    pl = '{251, 257, 509, 3};
    for (int i = 0; i < 1000; i++) begin
      p   = pl[$urandom_range(0, 3)];
      lim = (2 * p - 1 > 511) ? 511 : 2 * p - 1;
      for (int k = 0; k < N; k++) xv[k] = $urandom_range(0, lim);
      xfer(1'b1, p, pack3(xv[0], xv[1], xv[2]), y, e, lat);
      for (int k = 0; k < N; k++) begin
        checks++;
        if (ch(y, k) !== conv(1'b1, p, xv[k])) begin
          errors++;
          $display("FAIL rt_mont p=%0d x=%0d: got %0d want %0d", p, xv[k],
                   ch(y, k), conv(1'b1, p, xv[k]));
        end
      end
      xfer(1'b0, p, y, z, e, lat);
      for (int k = 0; k < N; k++) begin
        checks++;
        if (ch(z, k) !== xv[k] % p) begin
          errors++;
          $display("FAIL rt_back p=%0d x=%0d: got %0d want %0d", p, xv[k],
                   ch(z, k), xv[k] % p);
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    to_mont   = 1'b0;
    prime     = '0;
    x_in      = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_prereduce();
    test_backpressure();
    test_midrun_reset();
    test_back_to_back();
    test_err();
    test_roundtrip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
